// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if: line/tick inputs and received-word outputs of the
// oversampling UART receiver. The receiver attaches through the slave
// modport. The line driver and word consumer attach through the master modport.
interface uart_rx_oversample_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_stick;
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_busy;

  modport master (
    output i_stick, i_rx,
    input  o_data, o_valid, o_frame_err, o_parity_err, o_busy
  );

  modport slave (
    input  i_stick, i_rx,
    output o_data, o_valid, o_frame_err, o_parity_err, o_busy
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x/8x oversampling UART receiver. It finds the start
// bit, samples each bit at its midpoint, and emits one word per frame with
// valid / frame-error / parity-error pulses.
// Optional parity bit: define UART_RX_PARITY_EN.
// The DATA_BITS parameter of the connected interface must match DATA_BITS here.
module uart_rx_oversample #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  uart_rx_oversample_if.slave bus
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_END  = '1;
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_s;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err;
  logic                 r_rearm;
  logic                 w_tick_mid, w_tick_end;
  logic                 w_tcnt_clr, w_shift_en, w_par_chk, w_stop_smp;
  logic                 w_par_bad;

  assign w_tick_mid = bus.i_stick && (r_tcnt == TC_MID);
  assign w_tick_end = bus.i_stick && (r_tcnt == TC_END);

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s && !r_rearm) begin
          w_tcnt_clr  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick_mid) begin
          if (!r_rx_s) begin
            w_tcnt_clr  = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick_end) begin
          w_shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bcnt == BC_LAST) w_state_nxt = S_PARITY;
`else
          if (r_bcnt == BC_LAST) w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick_end) begin
          w_par_chk   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick_end) begin
          w_stop_smp  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick/bit counters, shift register, word register and result pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_rearm     <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_tcnt_clr) begin
        r_tcnt <= '0;
        r_bcnt <= '0;
      end else begin
        if (bus.i_stick) r_tcnt <= r_tcnt + 1'b1;
        if (w_shift_en)  r_bcnt <= r_bcnt + 1'b1;
      end
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      if (w_stop_smp) begin
        r_data      <= r_shift;
        r_valid     <= r_rx_s & ~w_par_bad;
        r_frame_err <= ~r_rx_s;
        // A low stop bit (e.g. a break) blocks the next start until the line returns high.
        r_rearm     <= ~r_rx_s;
      end else if (r_state == S_IDLE && r_rx_s) begin
        r_rearm <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, r_parity_err;

  // Parity verdict is latched at the parity sample and reported with the stop sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (w_tcnt_clr)     r_par_bad <= 1'b0;
      else if (w_par_chk) r_par_bad <= r_rx_s ^ (^r_shift) ^ PARITY_ODD;
      if (w_stop_smp)     r_parity_err <= r_par_bad;
    end
  end

  assign w_par_bad        = r_par_bad;
  assign bus.o_parity_err = r_parity_err;
`else
  logic w_unused_parity;
  assign w_unused_parity  = PARITY_ODD ^ w_par_chk;
  assign w_par_bad        = 1'b0;
  assign bus.o_parity_err = 1'b0;
`endif

  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed frames against uart_rx_oversample.
// The oversample tick is generated locally, one pulse every TICK_DIV clocks.
// Define UART_RX_PARITY_EN to include the parity scenario.
module tb_uart_rx_oversample;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic clk;
  logic rst_n;

  uart_rx_oversample_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_oversample #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_ODD(1'b0)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (rx_if)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int         n_valid = 0, n_ferr = 0, n_perr = 0, n_overlap = 0;
  logic [7:0] vdata [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_if.o_valid) begin
      if (n_valid < 16) vdata[n_valid] = rx_if.o_data;
      n_valid++;
    end
    if (rx_if.o_frame_err) n_ferr++;
    if (rx_if.o_parity_err) n_perr++;
    if (rx_if.o_valid && (rx_if.o_frame_err || rx_if.o_parity_err)) n_overlap++;
  end

  // Oversample tick generator.
  initial begin
    rx_if.i_stick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      rx_if.i_stick = 1'b1;
      @(negedge clk);
      rx_if.i_stick = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    rx_if.i_rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) begin end
`endif
    send_bit(stop);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_data"},  32'(rx_if.o_data),       32'h0);
    check({pfx, "_valid"}, 32'(rx_if.o_valid),      32'h0);
    check({pfx, "_ferr"},  32'(rx_if.o_frame_err),  32'h0);
    check({pfx, "_perr"},  32'(rx_if.o_parity_err), 32'h0);
    check({pfx, "_busy"},  32'(rx_if.o_busy),       32'h0);
  endtask

  initial begin
    logic [7:0] d3c;
    for (int i = 0; i < 16; i++) vdata[i] = 8'hEE;
    rx_if.i_rx = 1'b1;
    rst_n      = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // 0x55 with a good stop bit
    send_frame(8'h55, 1'b1, ^8'h55);
    check("f55_nvalid", 32'(n_valid), 32'd1);
    check("f55_data",   32'(vdata[0]), 32'h55);
    check("f55_ferr",   32'(n_ferr), 32'd0);
    check("f55_busy",   32'(rx_if.o_busy), 32'h0);

    // 4-tick low glitch on an idle line
    rx_if.i_rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx_if.i_rx = 1'b1;
    repeat (6 * TICK_DIV) @(negedge clk);
    check("glitch_busy",   32'(rx_if.o_busy), 32'h0);
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_nvalid", 32'(n_valid), 32'd1);
    check("glitch_nferr",  32'(n_ferr), 32'd0);
    check("glitch_data",   32'(rx_if.o_data), 32'h55);

    // 0xA3 with a low stop bit
    send_frame(8'hA3, 1'b0, ^8'hA3);
    rx_if.i_rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("fA3_nferr",  32'(n_ferr), 32'd1);
    check("fA3_data",   32'(rx_if.o_data), 32'hA3);
    check("fA3_nvalid", 32'(n_valid), 32'd1);

    // back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    repeat (BIT_CLKS) @(negedge clk);
    check("b2b_nvalid", 32'(n_valid), 32'd3);
    check("b2b_first",  32'(vdata[1]), 32'h00);
    check("b2b_second", 32'(vdata[2]), 32'hFF);

    // reset in the middle of data bit 3 of 0x3C, then 0x96
    d3c = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d3c[i]);
    rx_if.i_rx = d3c[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("midrst");
    rx_if.i_rx = 1'b1;
    rst_n      = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'h96, 1'b1, ^8'h96);
    repeat (BIT_CLKS) @(negedge clk);
    check("f96_nvalid", 32'(n_valid), 32'd4);
    check("f96_data",   32'(vdata[3]), 32'h96);
    check("f96_nferr",  32'(n_ferr), 32'd1);

    // break: line held low for 12 bit times
    rx_if.i_rx = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    rx_if.i_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("brk_nferr",  32'(n_ferr), 32'd2);
    check("brk_data",   32'(rx_if.o_data), 32'h00);
    check("brk_nvalid", 32'(n_valid), 32'd4);
    check("brk_busy",   32'(rx_if.o_busy), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check("par_bad_nperr",  32'(n_perr), 32'd1);
    check("par_bad_nvalid", 32'(n_valid), 32'd4);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("par_ok_nvalid",  32'(n_valid), 32'd5);
    check("par_ok_data",    32'(vdata[4]), 32'h07);
    check("par_ok_nperr",   32'(n_perr), 32'd1);
`else
    check("noparity_nperr", 32'(n_perr), 32'd0);
`endif

    check("overlap", 32'(n_overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
